// File: rtl/sia_wbm_pkg.sv
// Shared types for the SIA Wishbone master: SIA register addresses, FSM state encodings,
// the bus-side request record and the ack-acceptance rule.
package sia_wbm_pkg;

  localparam logic [2:0] SIA_ADR_STATUS = 3'd0;
  localparam logic [2:0] SIA_ADR_CONFIG = 3'd1;
  localparam logic [2:0] SIA_ADR_BITS   = 3'd2;
  localparam logic [2:0] SIA_ADR_DATA   = 3'd3;

  typedef enum logic [1:0] {
    SIA_WBM_IDLE     = 2'b00,
    SIA_WBM_STROBE   = 2'b01,
    SIA_WBM_WAIT_ACK = 2'b10,
    SIA_WBM_RESP     = 2'b11
  } sia_wbm_state_e;

  typedef struct packed {
    logic        we;
    logic [2:0]  adr;
    logic [15:0] dat;
    logic [1:0]  sel;
  } sia_wbm_req_t;

  // An ack only counts once the strobe has been (or is being) accepted.
  function automatic logic ack_taken(sia_wbm_state_e st, logic stall, logic ack);
    return ack && ((st == SIA_WBM_STROBE && !stall) || st == SIA_WBM_WAIT_ACK);
  endfunction

endpackage

// File: rtl/sia_wbm_watchdog.sv
// Cycle watchdog for sia_wbm: counts enabled cycles from a clear and flags the
// terminal count TIMEOUT-1.
module sia_wbm_watchdog #(
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      count <= '0;
    end else if (clear_i) begin
      count <= '0;
    end else if (enable_i && !expired_o) begin
      count <= count + 1'b1;
    end
  end

  assign expired_o = enable_i && (count == LAST);

endmodule

// File: rtl/sia_wbm.sv
// Single-outstanding Wishbone B.4 pipelined master for the SIA slave port.
// Optional watchdog abort is built when SIA_WBM_TIMEOUT_EN is defined.
//
// state    | meaning
// IDLE     | req_ready_o high, waiting for a command
// STROBE   | cyc/stb high, holding the bus until stall_i drops
// WAIT_ACK | strobe accepted, cyc high, waiting for ack_i
// RESP     | bus released, rsp_valid_o pulses on the following cycle
module sia_wbm
  import sia_wbm_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_adr_i,
  input  logic [15:0] req_dat_i,
  input  logic [1:0]  req_sel_i,
  output logic        rsp_valid_o,
  output logic [15:0] rsp_dat_o,
  output logic        rsp_err_o,
  output logic [2:0]  adr_o,
  output logic        we_o,
  output logic        cyc_o,
  output logic        stb_o,
  output logic [15:0] dat_o,
  output logic [1:0]  sel_o,
  input  logic [15:0] dat_i,
  input  logic        ack_i,
  input  logic        stall_i
);

  sia_wbm_state_e state, state_nxt;
  sia_wbm_req_t   bus_q, bus_nxt;
  logic           cyc_nxt, stb_nxt;
  logic [15:0]    rsp_dat_nxt;
  logic           ack_ok;
  logic           abort;

  assign ack_ok = ack_taken(state, stall_i, ack_i);

`ifdef SIA_WBM_TIMEOUT_EN
  logic wd_expired;
  logic err_q;

  sia_wbm_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk_i     (clk_i),
    .reset_ni  (reset_ni),
    .clear_i   (state == SIA_WBM_IDLE),
    .enable_i  (cyc_o),
    .expired_o (wd_expired)
  );

  // A coincident ack takes priority over the timeout.
  assign abort = wd_expired && !ack_ok &&
                 (state == SIA_WBM_STROBE || state == SIA_WBM_WAIT_ACK);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      err_q     <= 1'b0;
      rsp_err_o <= 1'b0;
    end else begin
      err_q     <= abort;
      rsp_err_o <= (state == SIA_WBM_RESP) && err_q;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign abort          = 1'b0;
  assign rsp_err_o      = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    bus_nxt     = bus_q;
    cyc_nxt     = cyc_o;
    stb_nxt     = stb_o;
    rsp_dat_nxt = rsp_dat_o;
    case (state)
      SIA_WBM_IDLE: begin
        if (req_valid_i) begin
          state_nxt   = SIA_WBM_STROBE;
          bus_nxt.we  = req_we_i;
          bus_nxt.adr = req_adr_i;
          bus_nxt.dat = req_dat_i;
          bus_nxt.sel = req_sel_i;
          cyc_nxt     = 1'b1;
          stb_nxt     = 1'b1;
        end
      end
      SIA_WBM_STROBE: begin
        if (ack_ok) begin
          state_nxt   = SIA_WBM_RESP;
          cyc_nxt     = 1'b0;
          stb_nxt     = 1'b0;
          bus_nxt.we  = 1'b0;
          bus_nxt.sel = 2'b00;
          rsp_dat_nxt = dat_i;
        end else if (abort) begin
          state_nxt   = SIA_WBM_RESP;
          cyc_nxt     = 1'b0;
          stb_nxt     = 1'b0;
          bus_nxt.we  = 1'b0;
          bus_nxt.sel = 2'b00;
          rsp_dat_nxt = 16'h0000;
        end else if (!stall_i) begin
          state_nxt   = SIA_WBM_WAIT_ACK;
          stb_nxt     = 1'b0;
          bus_nxt.we  = 1'b0;
          bus_nxt.sel = 2'b00;
        end
      end
      SIA_WBM_WAIT_ACK: begin
        if (ack_ok) begin
          state_nxt   = SIA_WBM_RESP;
          cyc_nxt     = 1'b0;
          rsp_dat_nxt = dat_i;
        end else if (abort) begin
          state_nxt   = SIA_WBM_RESP;
          cyc_nxt     = 1'b0;
          rsp_dat_nxt = 16'h0000;
        end
      end
      SIA_WBM_RESP: begin
        state_nxt = SIA_WBM_IDLE;
      end
      default: begin
        state_nxt = SIA_WBM_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state       <= SIA_WBM_IDLE;
      bus_q       <= '0;
      cyc_o       <= 1'b0;
      stb_o       <= 1'b0;
      rsp_dat_o   <= 16'h0000;
      rsp_valid_o <= 1'b0;
    end else begin
      state       <= state_nxt;
      bus_q       <= bus_nxt;
      cyc_o       <= cyc_nxt;
      stb_o       <= stb_nxt;
      rsp_dat_o   <= rsp_dat_nxt;
      rsp_valid_o <= (state == SIA_WBM_RESP);
    end
  end

  assign req_ready_o = (state == SIA_WBM_IDLE);
  assign we_o        = bus_q.we;
  assign adr_o       = bus_q.adr;
  assign dat_o       = bus_q.dat;
  assign sel_o       = bus_q.sel;

endmodule

// File: tb/tb_sia_wbm.sv
// Directed bench for sia_wbm: table of single transfers with hand-computed timing,
// plus back-to-back, watchdog (when SIA_WBM_TIMEOUT_EN) and mid-transfer reset sequences.
module tb_sia_wbm;
  import sia_wbm_pkg::*;

  logic        clk_i = 1'b0;
  logic        reset_ni;
  logic        req_valid_i, req_ready_o, req_we_i;
  logic [2:0]  req_adr_i;
  logic [15:0] req_dat_i;
  logic [1:0]  req_sel_i;
  logic        rsp_valid_o, rsp_err_o;
  logic [15:0] rsp_dat_o;
  logic [2:0]  adr_o;
  logic        we_o, cyc_o, stb_o;
  logic [15:0] dat_o;
  logic [1:0]  sel_o;
  logic [15:0] dat_i;
  logic        ack_i, stall_i;

  int n_cmp = 0;
  int n_err = 0;

  sia_wbm #(.TIMEOUT(8)) dut (
    .clk_i       (clk_i),
    .reset_ni    (reset_ni),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_we_i    (req_we_i),
    .req_adr_i   (req_adr_i),
    .req_dat_i   (req_dat_i),
    .req_sel_i   (req_sel_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_dat_o   (rsp_dat_o),
    .rsp_err_o   (rsp_err_o),
    .adr_o       (adr_o),
    .we_o        (we_o),
    .cyc_o       (cyc_o),
    .stb_o       (stb_o),
    .dat_o       (dat_o),
    .sel_o       (sel_o),
    .dat_i       (dat_i),
    .ack_i       (ack_i),
    .stall_i     (stall_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, got hang expected finish");
    $fatal(1, "global timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  adr;
    logic [15:0] dat;
    logic [1:0]  sel;
    int          stalls;
    int          ack_dly;
    bit          spur;
    logic [15:0] rdata;
    int          exp_stb;
    int          exp_cyc;
    int          exp_rsp;
    logic [15:0] exp_dat;
  } vec_t;

  vec_t vecs[5];

  task automatic run_vec(input int idx, input vec_t v);
    int stb_cnt = 0, cyc_cnt = 0, rsp_at = -1, bus_bad = 0, drop_bad = 0;
    @(negedge clk_i);
    chk($sformatf("v%0d_ready_idle", idx), 32'(req_ready_o), 32'd1);
    req_valid_i = 1'b1;
    req_we_i    = v.we;
    req_adr_i   = v.adr;
    req_dat_i   = v.dat;
    req_sel_i   = v.sel;
    for (int c = 0; c < 40 && rsp_at < 0; c++) begin
      @(negedge clk_i);
      if (c == 0) begin
        req_valid_i = 1'b0;
        req_dat_i   = 16'h0000;
      end
      if (stb_o) begin
        stb_cnt++;
        if (adr_o !== v.adr || sel_o !== v.sel || we_o !== v.we || dat_o !== v.dat) bus_bad++;
      end
      if (cyc_o) cyc_cnt++;
      if (cyc_o && !stb_o && (we_o !== 1'b0 || sel_o !== 2'b00)) drop_bad++;
      if (rsp_valid_o) begin
        rsp_at = c;
        chk($sformatf("v%0d_rsp_dat", idx), 32'(rsp_dat_o), 32'(v.exp_dat));
        chk($sformatf("v%0d_rsp_err", idx), 32'(rsp_err_o), 32'd0);
      end
      stall_i = (c < v.stalls);
      ack_i   = (c == v.stalls + v.ack_dly) || (v.spur && c == 0 && v.stalls > 0);
      dat_i   = (c == v.stalls + v.ack_dly) ? v.rdata : 16'hDEAD;
    end
    stall_i = 1'b0;
    ack_i   = 1'b0;
    chk($sformatf("v%0d_rsp_cycle", idx), 32'(rsp_at), 32'(v.exp_rsp));
    chk($sformatf("v%0d_stb_cycles", idx), 32'(stb_cnt), 32'(v.exp_stb));
    chk($sformatf("v%0d_cyc_cycles", idx), 32'(cyc_cnt), 32'(v.exp_cyc));
    chk($sformatf("v%0d_bus_stable", idx), 32'(bus_bad), 32'd0);
    chk($sformatf("v%0d_we_sel_drop", idx), 32'(drop_bad), 32'd0);
    @(negedge clk_i);
    chk($sformatf("v%0d_rsp_pulse_end", idx), 32'(rsp_valid_o), 32'd0);
    chk($sformatf("v%0d_ready_after", idx), 32'(req_ready_o), 32'd1);
  endtask

  initial begin
    //            we    adr             dat       sel    st ad sp rdata     stb cyc rsp exp_dat
    vecs[0] = '{1'b1, SIA_ADR_CONFIG, 16'h3F0F, 2'b11, 0, 1, 0, 16'h0000, 1, 2, 3, 16'h0000};
    vecs[1] = '{1'b0, 3'd2,           16'h0000, 2'b11, 3, 1, 0, 16'hA5C3, 4, 5, 6, 16'hA5C3};
    vecs[2] = '{1'b0, 3'd5,           16'h0000, 2'b01, 0, 0, 0, 16'h1234, 1, 1, 2, 16'h1234};
    vecs[3] = '{1'b1, 3'd7,           16'hFFFF, 2'b10, 2, 0, 1, 16'h0BAD, 3, 3, 4, 16'h0BAD};
    vecs[4] = '{1'b0, 3'd0,           16'h0000, 2'b11, 1, 3, 0, 16'h8001, 2, 5, 6, 16'h8001};

    reset_ni = 1'b0;
    req_valid_i = 1'b0; req_we_i = 1'b0; req_adr_i = '0; req_dat_i = '0; req_sel_i = '0;
    dat_i = '0; ack_i = 1'b0; stall_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("rst_cyc", 32'(cyc_o), 32'd0);
    chk("rst_stb", 32'(stb_o), 32'd0);
    chk("rst_bus", {13'd0, we_o, adr_o, dat_o}, 32'd0);
    chk("rst_sel", 32'(sel_o), 32'd0);
    chk("rst_rsp", {14'd0, rsp_valid_o, rsp_err_o, rsp_dat_o}, 32'd0);
    chk("rst_ready", 32'(req_ready_o), 32'd1);
    reset_ni = 1'b1;

    for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

    // Back-to-back with req_valid_i held: second command taken the edge after rsp_valid_o.
    begin
      bit done = 0;
      @(negedge clk_i);
      req_valid_i = 1'b1; req_we_i = 1'b0; req_adr_i = 3'd3; req_sel_i = 2'b11; req_dat_i = 16'h0;
      for (int c = 0; c < 30 && !done; c++) begin
        @(negedge clk_i);
        if (c == 0) begin
          req_we_i = 1'b1; req_adr_i = 3'd6; req_dat_i = 16'h5A5A; req_sel_i = 2'b11;
        end
        if (c == 2) chk("b2b_no_early_accept", {30'd0, req_ready_o, stb_o}, 32'd0);
        if (c == 3) begin
          chk("b2b_rsp_pulse", 32'(rsp_valid_o), 32'd1);
          chk("b2b_no_overlap", {30'd0, cyc_o, stb_o}, 32'd0);
        end
        if (c == 4) begin
          chk("b2b_second_strobe", {28'd0, stb_o, adr_o}, {28'd0, 1'b1, 3'd6});
          chk("b2b_second_we_dat", {15'd0, we_o, dat_o}, {15'd0, 1'b1, 16'h5A5A});
          req_valid_i = 1'b0;
        end
        if (c > 4 && rsp_valid_o) begin
          chk("b2b_second_rsp_dat", 32'(rsp_dat_o), 32'h0F0F);
          chk("b2b_second_rsp_cycle", 32'(c), 32'd7);
          done = 1;
        end
        ack_i = cyc_o && !stb_o;
        dat_i = (cyc_o && !stb_o) ? ((c < 4) ? 16'h1111 : 16'h0F0F) : 16'hDEAD;
      end
      ack_i = 1'b0;
      if (!done) chk("b2b_completion_seen", 32'd0, 32'd1);
    end

`ifdef SIA_WBM_TIMEOUT_EN
    begin
      int cyc_cnt = 0;
      bit seen = 0;
      @(negedge clk_i);
      req_valid_i = 1'b1; req_we_i = 1'b0; req_adr_i = 3'd1; req_sel_i = 2'b11;
      for (int c = 0; c < 30 && !seen; c++) begin
        @(negedge clk_i);
        req_valid_i = 1'b0;
        if (cyc_o) cyc_cnt++;
        if (rsp_valid_o) begin
          seen = 1;
          chk("to_rsp_err", 32'(rsp_err_o), 32'd1);
          chk("to_rsp_dat", 32'(rsp_dat_o), 32'd0);
        end
      end
      chk("to_rsp_seen", 32'(seen), 32'd1);
      chk("to_cyc_cycles", 32'(cyc_cnt), 32'd8);
    end
`endif

    // Reset while waiting for ack: bus clears asynchronously and no response follows.
    begin
      int rsp_cnt = 0;
      @(negedge clk_i);
      req_valid_i = 1'b1; req_we_i = 1'b0; req_adr_i = 3'd4; req_sel_i = 2'b11;
      @(negedge clk_i);
      req_valid_i = 1'b0; stall_i = 1'b0; ack_i = 1'b0;
      @(negedge clk_i);
      chk("rstw_pre_wait_ack", {30'd0, cyc_o, stb_o}, {30'd0, 2'b10});
      #2 reset_ni = 1'b0;
      #1;
      chk("rstw_async_cyc_stb", {30'd0, cyc_o, stb_o}, 32'd0);
      chk("rstw_async_adr", 32'(adr_o), 32'd0);
      repeat (2) @(negedge clk_i);
      reset_ni = 1'b1;
      @(negedge clk_i);
      chk("rstw_ready_after", 32'(req_ready_o), 32'd1);
      for (int c = 0; c < 5; c++) begin
        if (rsp_valid_o) rsp_cnt++;
        @(negedge clk_i);
      end
      chk("rstw_no_rsp", 32'(rsp_cnt), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sia_wbm.md
# sia_wbm

Wishbone B.4 pipelined single-transfer bus master that drives the 16-bit SIA slave port (sia_wb) from a simple valid/ready command interface. It lets a local sequencer, debug port or test driver issue SIA register reads and writes without implementing Wishbone itself. It sits between that requester and the SIA's adr/dat/sel/we/cyc/stb/ack/stall pins, with one transaction outstanding at a time.

## Interface
- TIMEOUT, 1000, cycles from cyc_o rise to abort (used only with the watchdog compiled in)
- clk_i  in  1  bus clock, rising edge
- reset_ni  in  1  asynchronous, active-low reset
- req_valid_i  in  1  command present
- req_ready_o  out  1  command accepted when high with req_valid_i
- req_we_i  in  1  1 = write, 0 = read
- req_adr_i  in  3  SIA register address [3:1], values from sia.vh
- req_dat_i  in  16  write data
- req_sel_i  in  2  byte lanes
- rsp_valid_o  out  1  one-cycle completion pulse
- rsp_dat_o  out  16  read data captured on ack
- rsp_err_o  out  1  transfer aborted by the watchdog
- adr_o  out  3  Wishbone address [3:1]
- we_o, cyc_o, stb_o  out  1 each  Wishbone controls
- dat_o  out  16  Wishbone write data
- sel_o  out  2  Wishbone byte selects
- dat_i  in  16  Wishbone read data
- ack_i, stall_i  in  1 each  Wishbone slave responses

## Operation
- States: IDLE, STROBE, WAIT_ACK, RESP.
- IDLE: req_ready_o=1. When req_valid_i is high at the clock edge, latch we/adr/dat/sel into the bus output registers, set cyc_o=stb_o=1, and go to STROBE.
- STROBE: hold stb_o and all bus outputs stable while stall_i=1. At an edge with stall_i=0, the strobe is accepted: drop stb_o, sel_o and we_o. If ack_i=1 at that same edge, go to RESP; otherwise go to WAIT_ACK. Ignore ack_i while stall_i=1.
- WAIT_ACK: cyc_o=1, stb_o=0. When ack_i=1, go to RESP.
- At every accepted ack, capture dat_i into rsp_dat_o, including on writes. rsp_dat_o holds its value until the next ack or abort.
- RESP: cyc_o=0, rsp_valid_o=1 for exactly one cycle, then return to IDLE.
- req_ready_o is combinational (state==IDLE). Its reset value is therefore 1, but no request is taken while reset_ni=0.
- rsp_err_o is valid only with rsp_valid_o, and is 0 for normal completions.
- Reset values: state IDLE; cyc_o, stb_o, we_o, sel_o, adr_o, dat_o, rsp_valid_o, rsp_err_o = 0; rsp_dat_o = 16'h0000.
- Reset mid-transfer: all bus outputs clear immediately (asynchronous) and no response is issued.

## Timing
- Request accepted at edge N -> cyc_o and stb_o high after edge N.
- Zero stall and ack one cycle after the strobe (normal sia_wb behaviour): stb_o high for 1 cycle, cyc_o for 2, rsp_valid_o after edge N+3, next request accepted at edge N+4.
- Each stall cycle adds one cycle. Ack on the strobe-acceptance edge saves one cycle.
- Minimum throughput: one transfer per 3 cycles; 4 cycles for the normal sia_wb ack.

## Configuration
- SIA_WBM_TIMEOUT_EN defined:
  - A watchdog counts every cycle cyc_o is high, from 0 at the cyc_o rise.
  - If the count reaches TIMEOUT-1 with no accepted ack, the transfer aborts: drop cyc_o and stb_o, go to RESP with rsp_err_o=1 and rsp_dat_o=16'h0000.
  - An ack on the same edge as the timeout wins: normal completion.
- SIA_WBM_TIMEOUT_EN undefined:
  - No counter is built, and a transfer waits for ack indefinitely.
  - rsp_err_o is tied 0 and TIMEOUT is unused.

## Structure
- State encodings (SIA_WBM_IDLE, SIA_WBM_STROBE, SIA_WBM_WAIT_ACK, SIA_WBM_RESP) go in sia.vh next to the existing SIA_ADR_* constants.
- The watchdog is the sub-module sia_wbm_watchdog. It has clear/enable inputs and an expired output, and is instantiated only under SIA_WBM_TIMEOUT_EN.

## Test plan
- Write SIA_ADR_CONFIG with data 16'h3F0F and sel 11 against a real sia_wb -> one stb_o cycle, cyc_o two cycles, rsp_valid_o 3 cycles after acceptance, and sia_wb bits_o reads back 15.
- Read with stall_i held high for 3 cycles, then ack with dat_i=16'hA5C3 -> stb_o held 4 cycles with adr/sel stable, rsp_dat_o=16'hA5C3, rsp_err_o=0.
- Ack on the same edge as strobe acceptance -> RESP entered directly, and rsp_valid_o 2 cycles after acceptance.
- Back-to-back requests with req_valid_i held high -> second acceptance exactly at the edge after the rsp_valid_o pulse; no overlapping cyc_o.
- With SIA_WBM_TIMEOUT_EN and TIMEOUT=8, ack never asserted -> cyc_o high 8 cycles, then rsp_valid_o=1, rsp_err_o=1, rsp_dat_o=0.
- reset_ni pulled low while in WAIT_ACK -> cyc_o/stb_o cleared without waiting for a clock edge, no rsp_valid_o, and req_ready_o=1 after release.
